// File: rtl/i2c_master_frame_ctrl_if.sv
// Host request/response and byte-engine command bundle for the I2C frame sequencer.
// master: the frame sequencer; slave: the host plus the byte engine facing it.
interface i2c_master_frame_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [6:0]  req_dev;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        bcmd_valid;
  logic        bcmd_ready;
  logic [2:0]  bcmd_op;
  logic [7:0]  bcmd_data;
  logic        bcmd_last;
  logic        bdone;
  logic [7:0]  brx_data;
  logic        brx_ack;

  modport master (
    input  req_valid, req_rw, req_dev, req_addr, req_wdata,
    input  bcmd_ready, bdone, brx_data, brx_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bcmd_valid, bcmd_op, bcmd_data, bcmd_last
  );

  modport slave (
    output req_valid, req_rw, req_dev, req_addr, req_wdata,
    output bcmd_ready, bdone, brx_data, brx_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bcmd_valid, bcmd_op, bcmd_data, bcmd_last
  );
endinterface

// File: rtl/i2c_master_frame_ctrl.sv
// Turns one 32-bit register write/read request into START/WRITE/READ/STOP byte-engine ops.
// Define I2C_FRAME_RETRY_EN to retry device-address NACKs up to MAX_RETRY times.
module i2c_master_frame_ctrl #(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  i2c_master_frame_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV_W, S_ADDR, S_WDATA,
    S_RESTART, S_DEV_R, S_RDATA, S_STOP, S_RESP
  } state_t;

  localparam logic [2:0] OP_START   = 3'd0;
  localparam logic [2:0] OP_RESTART = 3'd1;
  localparam logic [2:0] OP_WRITE   = 3'd2;
  localparam logic [2:0] OP_READ    = 3'd3;
  localparam logic [2:0] OP_STOP    = 3'd4;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DEV  = 2'b01;
  localparam logic [1:0] ERR_BYTE = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);
  localparam int         TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (ADDR_BYTES < 1 || ADDR_BYTES > 2 || DATA_BYTES < 1 || DATA_BYTES > 4 ||
      TIMEOUT_CYCLES < 2 || MAX_RETRY < 0) begin : g_bad_param
    $error("i2c_master_frame_ctrl: parameter out of range");
  end

  // Byte idx counts from the least significant byte of the word.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  state_t        state_q, state_d;
  logic          wait_q, wait_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    err_q, err_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_err_q, rsp_err_d;
  logic          bcmd_valid_q, bcmd_valid_d;
  logic [2:0]    bcmd_op_q, bcmd_op_d;
  logic [7:0]    bcmd_data_q, bcmd_data_d;
  logic          bcmd_last_q, bcmd_last_d;
`ifdef I2C_FRAME_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_d;
`endif

  logic   go;
  state_t go_state;
  logic   in_op;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    rw_d     = rw_q;
    dev_d    = dev_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    go       = 1'b0;
    go_state = state_q;
`ifdef I2C_FRAME_RETRY_EN
    retry_d  = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          rw_d     = bus.req_rw;
          dev_d    = bus.req_dev;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          err_d    = ERR_OK;
          go       = 1'b1;
          go_state = S_START;
`ifdef I2C_FRAME_RETRY_EN
          retry_d  = '0;
`endif
        end
      end
      S_RESP: begin
        go       = 1'b1;
        go_state = S_IDLE;
      end
      default: begin
        if (!wait_q && bus.bcmd_ready) begin
          wait_d = 1'b1;
          tmo_d  = '0;
        end else if (wait_q && bus.bdone) begin
          go = 1'b1;
          case (state_q)
            S_START:   go_state = S_DEV_W;
            S_RESTART: go_state = S_DEV_R;
            S_DEV_W, S_DEV_R: begin
              if (bus.brx_ack) begin
                err_d    = ERR_DEV;
                go_state = S_STOP;
              end else begin
                go_state = (state_q == S_DEV_W) ? S_ADDR : S_RDATA;
              end
            end
            S_ADDR: begin
              if (bus.brx_ack) begin
                err_d    = ERR_BYTE;
                go_state = S_STOP;
              end else if (cnt_q == ADDR_LAST) begin
                go_state = rw_q ? S_RESTART : S_WDATA;
              end else begin
                go    = 1'b0;
                wait_d = 1'b0;
                tmo_d = '0;
                cnt_d = cnt_q + 2'd1;
              end
            end
            S_WDATA: begin
              if (bus.brx_ack) begin
                err_d    = ERR_BYTE;
                go_state = S_STOP;
              end else if (cnt_q == DATA_LAST) begin
                go_state = S_STOP;
              end else begin
                go     = 1'b0;
                wait_d = 1'b0;
                tmo_d  = '0;
                cnt_d  = cnt_q + 2'd1;
              end
            end
            S_RDATA: begin
              rdata_d = {rdata_q[23:0], bus.brx_data};
              if (cnt_q == DATA_LAST) begin
                go_state = S_STOP;
              end else begin
                go     = 1'b0;
                wait_d = 1'b0;
                tmo_d  = '0;
                cnt_d  = cnt_q + 2'd1;
              end
            end
            default: begin
              go_state = S_RESP;
`ifdef I2C_FRAME_RETRY_EN
              if (err_q == ERR_DEV && retry_q != RETRY_MAX) begin
                retry_d  = retry_q + RW'(1);
                err_d    = ERR_OK;
                rdata_d  = '0;
                go_state = S_START;
              end
`endif
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          // Engine presumed hung: answer without a STOP.
          err_d    = ERR_TMO;
          go       = 1'b1;
          go_state = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase

    if (go) begin
      state_d = go_state;
      wait_d  = 1'b0;
      cnt_d   = '0;
      tmo_d   = '0;
    end

    // Outputs are derived from next state so they register cleanly.
    in_op        = !(state_d inside {S_IDLE, S_RESP});
    req_ready_d  = (state_d == S_IDLE);
    rsp_valid_d  = (state_d == S_RESP);
    rsp_rdata_d  = (state_d == S_RESP) ? rdata_d : '0;
    rsp_err_d    = (state_d == S_RESP) ? err_d : ERR_OK;
    bcmd_valid_d = in_op && !wait_d;
    bcmd_op_d    = OP_START;
    bcmd_data_d  = '0;
    bcmd_last_d  = 1'b0;
    if (bcmd_valid_d) begin
      case (state_d)
        S_RESTART: bcmd_op_d = OP_RESTART;
        S_DEV_W: begin
          bcmd_op_d   = OP_WRITE;
          bcmd_data_d = {dev_d, 1'b0};
        end
        S_DEV_R: begin
          bcmd_op_d   = OP_WRITE;
          bcmd_data_d = {dev_d, 1'b1};
        end
        S_ADDR: begin
          bcmd_op_d   = OP_WRITE;
          bcmd_data_d = byte_sel({16'd0, addr_d}, ADDR_LAST - cnt_d);
        end
        S_WDATA: begin
          bcmd_op_d   = OP_WRITE;
          bcmd_data_d = byte_sel(wdata_d, DATA_LAST - cnt_d);
        end
        S_RDATA: begin
          bcmd_op_d   = OP_READ;
          bcmd_last_d = (cnt_d == DATA_LAST);
        end
        S_STOP:  bcmd_op_d = OP_STOP;
        default: bcmd_op_d = OP_START;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_q       <= 1'b0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      rw_q         <= 1'b0;
      dev_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= ERR_OK;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= ERR_OK;
      bcmd_valid_q <= 1'b0;
      bcmd_op_q    <= OP_START;
      bcmd_data_q  <= '0;
      bcmd_last_q  <= 1'b0;
`ifdef I2C_FRAME_RETRY_EN
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      rw_q         <= rw_d;
      dev_q        <= dev_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      bcmd_valid_q <= bcmd_valid_d;
      bcmd_op_q    <= bcmd_op_d;
      bcmd_data_q  <= bcmd_data_d;
      bcmd_last_q  <= bcmd_last_d;
`ifdef I2C_FRAME_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.bcmd_valid = bcmd_valid_q;
  assign bus.bcmd_op    = bcmd_op_q;
  assign bus.bcmd_data  = bcmd_data_q;
  assign bus.bcmd_last  = bcmd_last_q;

endmodule

// File: doc/i2c_master_frame_ctrl.md
Name: i2c_master_frame_ctrl

Overview:
Initiator-side frame sequencer for the register-access I2C protocol served by the target bridge. The frame format is a 7-bit device address, a 16-bit register address sent MSB first, then 32-bit data sent MSB first. The block converts one host request (write or read of a 32-bit register) into a sequence of byte-level ops for the I2C master byte engine. It collects the read data and ack status, then returns one response per request.

Parameters:
ADDR_BYTES, 2, register-address bytes per frame (1..2), MSB first.
DATA_BYTES, 4, data bytes per frame (1..4), MSB first.
TIMEOUT_CYCLES, 4096, max clk cycles to wait for bdone per op before abort.
MAX_RETRY, 3, device-NACK retry limit; used only with I2C_FRAME_RETRY_EN.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  host request valid
req_ready  out  1  high only in IDLE
req_rw  in  1  0=write, 1=read
req_dev  in  7  7-bit target device address
req_addr  in  16  register address
req_wdata  in  32  write data, MSB byte sent first
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  read data; 0 for writes
rsp_err  out  2  00 ok, 01 device NACK, 10 data/addr-byte NACK, 11 timeout
bcmd_valid  out  1  byte-engine op valid
bcmd_ready  in  1  engine accepts op
bcmd_op  out  3  0 START, 1 RESTART, 2 WRITE, 3 READ, 4 STOP
bcmd_data  out  8  byte for WRITE
bcmd_last  out  1  on READ: master sends NACK after this byte
bdone  in  1  one-cycle pulse: current op finished
brx_data  in  8  received byte, valid with bdone of READ
brx_ack  in  1  ack bit sampled after WRITE; 0=ACK, 1=NACK

Behaviour:
- Reset values: req_ready=0 during reset and 1 in IDLE after reset. All other outputs = 0. State = IDLE, counters = 0.
- Request capture: on req_valid&&req_ready, latch rw, dev, addr, wdata. Next cycle bcmd_valid=1 with op START.
- Op handshake, per op:
  - ISSUE: hold bcmd_valid, bcmd_op, bcmd_data and bcmd_last stable until bcmd_ready.
  - WAIT: bcmd_valid=0. Wait for bdone.
  - bdone is ignored outside WAIT.
- Write frame: START, WRITE {dev,0}, ADDR_BYTES x WRITE addr, DATA_BYTES x WRITE wdata, STOP.
- Read frame: START, WRITE {dev,0}, ADDR_BYTES x WRITE addr, RESTART, WRITE {dev,1}, DATA_BYTES x READ, STOP.
  - bcmd_last=1 only on the final READ.
- States: IDLE, START, DEV_W, ADDR, WDATA, RESTART, DEV_R, RDATA, STOP, RESP. A byte counter 0..3 indexes bytes MSB-first and resets on each state entry.
- Read data shifts in as rdata <= {rdata[23:0], brx_data} on each READ bdone. With DATA_BYTES<4 the upper bits are 0.
- NACK handling:
  - brx_ack=1 on a DEV_W or DEV_R byte: err=01, go to STOP.
  - brx_ack=1 on an ADDR or WDATA byte: err=10, go to STOP. No further data bytes are sent.
  - The STOP op is always issued after a NACK.
- Timeout:
  - A counter runs in ISSUE and WAIT and clears on each op handshake.
  - On reaching TIMEOUT_CYCLES-1 without progress: err=11, go directly to RESP. No STOP is issued, because the engine is presumed hung. bcmd_valid drops.
- RESP: rsp_valid=1 for exactly one cycle, with rsp_rdata and rsp_err. Next cycle IDLE and req_ready=1.
  - Minimum gap between responses and the next accept is 1 cycle.
  - On error, rsp_rdata holds the partially shifted value.
- Asynchronous reset mid-frame: immediate return to IDLE, no STOP issued, outputs at reset values. Bus recovery is the engine's job.
- req_valid in non-IDLE states is ignored, not queued.

Optional Feature:
Macro I2C_FRAME_RETRY_EN.
- Defined: a device NACK (err 01) after the STOP op completes restarts the frame from START, up to MAX_RETRY times. A retry counter is cleared on each new request. A response with err=01 is given only after MAX_RETRY+1 failed attempts. Data NACKs and timeouts are never retried.
- Undefined: no retry logic; a device NACK responds after a single attempt.

Test Plan:
- Write dev=0x2A, addr=0x0010, wdata=0xDEADBEEF, engine always ACKs -> ops START, WRITE 0x54, 0x00, 0x10, 0xDE, 0xAD, 0xBE, 0xEF, STOP; then rsp_valid with err=00 and rdata=0.
- Read dev=0x2A, addr=0x0004, engine returns 0x12, 0x34, 0x56, 0x78 -> ops START, WRITE 0x54, 0x00, 0x04, RESTART, WRITE 0x55, READ x4 with bcmd_last only on the 4th, STOP; then rsp_rdata=0x12345678 and err=00.
- Write where brx_ack=1 on the first byte (0x54) -> no addr bytes sent, STOP issued, err=01. With I2C_FRAME_RETRY_EN and MAX_RETRY=3 -> 4 START sequences before the response.
- Write where the 2nd data byte is NACKed -> remaining data bytes skipped, STOP issued, err=10.
- bcmd_ready held 0 after the START issue -> after TIMEOUT_CYCLES cycles rsp_valid with err=11, no STOP op, req_ready=1 the following cycle.
- rst_n asserted during RDATA, then released -> all outputs 0 during reset, IDLE afterwards. A fresh write after release completes normally with err=00.
